ps2_keymap_rx: RTL
==================

# ps2_keymap_rx

Parametrised PS/2 keyboard receiver and key-state tracker that runs entirely in the system clock domain. It oversamples and filters `ps2_clk`, then deframes 11-bit PS/2 frames with start, parity and stop checks. It decodes scan-code set 2 make, break (`F0`) and extended (`E0`) sequences, and maintains held state plus press/release pulses for a configurable table of keys. It sits between the board PS/2 pins and the menu/game control logic, and supports multiple simultaneous keys and extended keys such as the arrow keys.

## Interface
- `NUM_KEYS`, 4: number of tracked keys.
- `KEY_CODES`, `{9'h075 | 9'h100, 9'h05A, 9'h01B, 9'h01D}` (Up-arrow ext, Enter, S, W): `NUM_KEYS*9` bits. Entry i is `KEY_CODES[9*i+8 : 9*i]` = `{ext, code[7:0]}`.
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 200000: clk cycles without a PS/2 falling edge before a partial frame is aborted (2 ms at 100 MHz).

Ports:
- `clk` input 1: system clock, 100 MHz.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ps2_clk` input 1: PS/2 clock pin, asynchronous to `clk`.
- `ps2_dat` input 1: PS/2 data pin, asynchronous to `clk`.
- `byte_valid` output 1: one-cycle pulse when a good frame is received.
- `byte_data` output 8: last good byte; holds its value between pulses.
- `frame_err` output 1: one-cycle pulse on a parity, stop or timeout error.
- `key_held` output `NUM_KEYS`: bit i is 1 while key i is held.
- `key_down` output `NUM_KEYS`: one-cycle pulse when key i goes from released to held.
- `key_up` output `NUM_KEYS`: one-cycle pulse when key i goes from held to released.

## Operation
- **Input conditioning.** Both pins pass through 2-FF synchronisers. Filtered clock level flips only after `FILTER_LEN` consecutive samples disagree with it. A falling edge of the filtered clock produces one sample strobe; `ps2_dat` (synchronised) is sampled on that strobe.
- **Deframer FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with dat=0 (start bit), go to DATA with bit count 0. A strobe with dat=1 is ignored.
  - DATA: shift 8 bits, LSB first; after bit 7, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: if dat=1 and odd parity over data+parity holds, pulse `byte_valid` and update `byte_data`. Otherwise pulse `frame_err`. Either way, go to IDLE.
- **Timeout.** A timeout counter runs in every state except IDLE and resets on each strobe. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE and `frame_err` pulses.
- **Decoder prefix flags** `ext` and `brk` are updated per `byte_valid`:
  - `E0` sets `ext`.
  - `F0` sets `brk`.
  - Any other byte is a key code: it is compared against every table entry with `{ext, byte}`, then both flags clear.
- **Match on key i:**
  - `brk`=0 and not held: set held and pulse `key_down[i]`.
  - `brk`=0 and already held (typematic repeat): no change, no pulse.
  - `brk`=1 and held: clear held and pulse `key_up[i]`.
  - `brk`=1 and not held: no change.
- **Other decoder rules:**
  - An unmatched code clears the flags only.
  - Duplicate table entries update all matching bits.
  - `frame_err` clears `ext` and `brk`. Held keys are unaffected.
- **Multiple keys** are tracked independently. Any combination of `key_held` bits may be 1 at the same time.

## Timing
- **Reset.** All outputs are 0, the FSM is in IDLE, flags are clear, filter state is 1 (idle high), and synchronisers are 1. Reset mid-frame discards the partial frame with no error pulse.
- **Pin-to-strobe latency.** From a `ps2_clk` falling pin edge to the strobe is 2 + `FILTER_LEN` cycles, ±1 cycle.
- **Frame completion.** `byte_valid` or `frame_err` is asserted the cycle after the stop-bit strobe.
- **Key outputs.** `key_held`, `key_down` and `key_up` change the cycle after `byte_valid`; pulses last exactly one cycle.
- **Back-to-back frames.** No minimum gap beyond the PS/2 protocol is required. The decoder finishes within 1 cycle, long before the next byte arrives.
- **Glitches.** A glitch shorter than `FILTER_LEN` cycles on `ps2_clk` produces no strobe.

## Test plan
- **Basic make/break.** Send `1D`, then `F0 1D`, at a 12.5 kHz PS/2 clock.
  - After `1D`: `key_down[0]` pulses once and `key_held[0]`=1.
  - After `F0 1D`: `key_up[0]` pulses and `key_held[0]`=0.
  - `byte_data` reads `1D`, `F0`, `1D` in turn.
- **Extended key vs. non-extended code.**
  - `E0 75` sets `key_held[3]`=1; `E0 F0 75` clears it.
  - A plain `75` changes nothing.
- **Overlapping keys and repeat.** Send `1D 1B 1D 1D F0 1B`.
  - `key_held` ends at 4'b0001.
  - `key_down[0]` pulses only once; the repeated `1D` bytes produce no pulse.
  - `key_up[1]` pulses once.
- **Frame errors.**
  - Bad parity on `5A`: `frame_err` pulses, no `byte_valid`, `key_held[2]` stays 0.
  - Stop bit 0: `frame_err` pulses.
  - `F0` followed by a corrupted frame, then `5A`: this is treated as a make, so `key_held[2]`=1.
- **Timeout.** Stop the PS/2 clock after 4 data bits and hold idle for 200000 cycles.
  - `frame_err` pulses once.
  - The next full `1B` frame decodes correctly.
- **Glitch and reset.**
  - A 5-cycle low pulse on `ps2_clk` causes no strobe and no bit shift.
  - Asserting `rst_n` low mid-frame, while `key_held`=4'b0011, gives all-zero outputs immediately. After release, a new `1D` frame decodes normally.

Source files
------------

// File: rtl/ps2_keymap_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit deframer, and scan-code set 2
// decoder that tracks held state and press/release pulses for a table of keys.
module ps2_keymap_rx #(
  parameter int unsigned             NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {9'h075 | 9'h100, 9'h05A, 9'h01B, 9'h01D},
  parameter int unsigned             FILTER_LEN     = 8,
  parameter int unsigned             TIMEOUT_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                frame_err,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_up
);

  localparam int unsigned    FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0]  FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, strobe;
  logic [FW-1:0] fcnt;

  // The strobe fires on the same edge the filtered level drops, so it is already registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= 1'b1;
      fcnt   <= '0;
      strobe <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
      strobe <= 1'b0;
      if (clk_s2 != filt) begin
        if (fcnt == FLT_LAST) begin
          filt   <= clk_s2;
          fcnt   <= '0;
          strobe <= ~clk_s2;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  state_t        state, state_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          valid_n, err_n;

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    par_n   = par;
    tmo_n   = tmo;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (state != IDLE) begin
      if (strobe) begin
        tmo_n = '0;
      end else if (tmo == TMO_LAST) begin
        state_n = IDLE;
        err_n   = 1'b1;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end
    if (strobe) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n = DATA;
            bcnt_n  = '0;
            tmo_n   = '0;
          end
        end
        DATA: begin
          shreg_n = {dat_s2, shreg[7:1]};
          bcnt_n  = bcnt + 1'b1;
          if (bcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          if (dat_s2 && (^{shreg, par})) valid_n = 1'b1;
          else                           err_n   = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bcnt       <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bcnt       <= bcnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      tmo        <= tmo_n;
      byte_valid <= valid_n;
      frame_err  <= err_n;
      if (valid_n) byte_data <= shreg;
    end
  end

  logic                ext, brk, is_code;
  logic [NUM_KEYS-1:0] match, down_n, up_n, held_n;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      match[i] = (KEY_CODES[9*i +: 9] == {ext, byte_data});
    is_code = byte_valid && (byte_data != 8'hE0) && (byte_data != 8'hF0);
    down_n  = (is_code && !brk) ? (match & ~key_held) : '0;
    up_n    = (is_code &&  brk) ? (match &  key_held) : '0;
    held_n  = (key_held | down_n) & ~up_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      key_held <= '0;
      key_down <= '0;
      key_up   <= '0;
    end else begin
      key_held <= held_n;
      key_down <= down_n;
      key_up   <= up_n;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == 8'hE0)      ext <= 1'b1;
        else if (byte_data == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule
